alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: grant, execute, respond.
// Define ALU_ARB_ROUND_ROBIN_EN to alternate priority on conflicts; otherwise requester 0 wins.
module alu_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_op1_0,
  input  logic [W-1:0] req_op2_0,
  input  logic [W-1:0] req_op1_1,
  input  logic [W-1:0] req_op2_1,
  input  logic [2:0]   req_sel_0,
  input  logic [2:0]   req_sel_1,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_bgt,
  input  logic         alu_beq,
  input  logic         alu_bne,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_bgt,
  output logic         rsp_beq,
  output logic         rsp_bne,
  output logic         rsp_dz,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [2:0]     sel_q, sel_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   result_q, result_d;
  logic           bgt_q, bgt_d, beq_q, beq_d, bne_q, bne_d, dz_q, dz_d;
  logic           grant;
  logic           div_zero;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // On conflict the pointer decides; a lone request always wins.
  always_comb begin
    grant = ptr_q;
    if (req_valid != 2'b11) grant = req_valid[1];
  end
`else
  always_comb begin
    grant = ~req_valid[0];
  end
`endif

  assign div_zero = (sel_q == 3'd7) && (op2_q == '0);

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sel_d     = sel_q;
    owner_d   = owner_q;
    result_d  = result_q;
    bgt_d     = bgt_q;
    beq_d     = beq_q;
    bne_d     = bne_q;
    dz_d      = dz_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so no accept is ever signalled while held in reset.
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready[grant] = 1'b1;
          op1_d   = grant ? req_op1_1 : req_op1_0;
          op2_d   = grant ? req_op2_1 : req_op2_0;
          sel_d   = grant ? req_sel_1 : req_sel_0;
          owner_d = grant;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = div_zero ? '0 : alu_out;
        dz_d     = div_zero;
        bgt_d    = alu_bgt;
        beq_d    = alu_beq;
        bne_d    = alu_bne;
        state_d  = StResp;
      end
      StResp: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = StIdle;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          ptr_d   = ~owner_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op1_q    <= '0;
      op2_q    <= '0;
      sel_q    <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      bgt_q    <= 1'b0;
      beq_q    <= 1'b0;
      bne_q    <= 1'b0;
      dz_q     <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sel_q    <= sel_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      bgt_q    <= bgt_d;
      beq_q    <= beq_d;
      bne_q    <= bne_d;
      dz_q     <= dz_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign alu_in1    = op1_q;
  assign alu_in2    = op2_q;
  assign alu_sel    = sel_q;
  assign rsp_result = result_q;
  assign rsp_bgt    = bgt_q;
  assign rsp_beq    = beq_q;
  assign rsp_bne    = bne_q;
  assign rsp_dz     = dz_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a transaction-level reference model.
// Honours ALU_ARB_ROUND_ROBIN_EN in the model's arbitration rule.
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic         clk, rst_n;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0] req_op1_0, req_op2_0, req_op1_1, req_op2_1;
  logic [2:0]   req_sel_0, req_sel_1, alu_sel;
  logic [W-1:0] alu_in1, alu_in2, alu_out, rsp_result;
  logic         alu_bgt, alu_beq, alu_bne;
  logic         rsp_bgt, rsp_beq, rsp_bne, rsp_dz, busy;

  int checks = 0;
  int failures = 0;

  // Model: an accepted op answers two cycles later and stays until its owner accepts.
  bit           m_pending = 0;
  int           m_age = 0;
  bit           m_owner = 0;
  bit           m_ptr = 0;
  logic [W-1:0] e_result;
  bit           e_bgt, e_beq, e_bne, e_dz;
  bit           obs_grant[$];
  logic [W-1:0] obs_result[$];

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1_0(req_op1_0), .req_op2_0(req_op2_0),
    .req_op1_1(req_op1_1), .req_op2_1(req_op2_1),
    .req_sel_0(req_sel_0), .req_sel_1(req_sel_1),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_bgt(alu_bgt), .alu_beq(alu_beq), .alu_bne(alu_bne),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_bgt(rsp_bgt), .rsp_beq(rsp_beq),
    .rsp_bne(rsp_bne), .rsp_dz(rsp_dz), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [2:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    case (s)
      3'd0: r = '0;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a + b;
      3'd5: r = a - b;
      3'd6: r = a * b;
      default: r = (b == '0) ? '0 : a / b;
    endcase
    return r;
  endfunction

  // Shared ALU; returns garbage on divide-by-zero so the arbiter must zero it.
  always_comb begin
    alu_out = ref_op(alu_sel, alu_in1, alu_in2);
    if (alu_sel == 3'd7 && alu_in2 == '0) alu_out = '1;
    alu_bgt = alu_in1 > alu_in2;
    alu_beq = alu_in1 == alu_in2;
    alu_bne = alu_in1 != alu_in2;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pick(input logic [1:0] v);
    bit fav;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    fav = m_ptr;
`else
    fav = 1'b0;
`endif
    return v[fav] ? fav : ~fav;
  endfunction

  task automatic step(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [2:0] s0, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic [2:0] s1, input logic [1:0] rr);
    logic [1:0]   exp_rdy, exp_rv;
    bit           g;
    logic [W-1:0] a, b;
    logic [2:0]   s;
    @(negedge clk);
    req_valid = v; rsp_ready = rr;
    req_op1_0 = a0; req_op2_0 = b0; req_sel_0 = s0;
    req_op1_1 = a1; req_op2_1 = b1; req_sel_1 = s1;
    #1;
    exp_rdy = 2'b00;
    exp_rv  = 2'b00;
    if (!m_pending && v != 2'b00) exp_rdy = 2'b01 << pick(v);
    if (m_pending && m_age >= 2) exp_rv = 2'b01 << m_owner;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_rv);
    check("busy", busy, m_pending);
    if (req_ready != 2'b00) obs_grant.push_back(req_ready[1]);
    if (exp_rv != 2'b00) begin
      check("rsp_result", rsp_result, e_result);
      check("rsp_flags", {rsp_bgt, rsp_beq, rsp_bne, rsp_dz}, {e_bgt, e_beq, e_bne, e_dz});
      obs_result.push_back(rsp_result);
    end
    if (!m_pending && v != 2'b00) begin
      g = pick(v);
      a = g ? a1 : a0;
      b = g ? b1 : b0;
      s = g ? s1 : s0;
      m_pending = 1; m_age = 1; m_owner = g;
      e_result = ref_op(s, a, b);
      e_dz  = (s == 3'd7) && (b == '0);
      e_bgt = a > b; e_beq = a == b; e_bne = a != b;
    end else if (m_pending) begin
      if (m_age >= 2 && rr[m_owner]) begin
        m_pending = 0;
        m_ptr = ~m_owner;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic idle(input logic [1:0] rr);
    step(2'b00, '0, '0, 3'd0, '0, '0, 3'd0, rr);
  endtask

  task automatic do_reset(input logic pre_busy);
    @(negedge clk);
    check("busy_before_reset", busy, pre_busy);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_payload", {rsp_result, rsp_bgt, rsp_beq, rsp_bne, rsp_dz}, '0);
    @(negedge clk);
    check("rst_held_valid", rsp_valid, 2'b00);
    req_valid = 2'b00;
    rst_n = 1'b1;
    m_pending = 0; m_ptr = 0;
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op1_0 = '0; req_op2_0 = '0; req_op1_1 = '0; req_op2_1 = '0;
    req_sel_0 = '0; req_sel_1 = '0;
    do_reset(1'bx === 1'bx ? busy : 1'b0);

    // Single add: 7 + 5
    step(2'b01, 7, 5, 3'd4, '0, '0, 3'd0, 2'b00);
    idle(2'b00);
    idle(2'b00);
    check("single_valid", rsp_valid, 2'b01);
    check("single_result", rsp_result, 12);
    check("single_flags", {rsp_bgt, rsp_beq, rsp_bne, rsp_dz}, 4'b1010);
    idle(2'b01);
    idle(2'b00);

    // Divide by zero from requester 1
    step(2'b10, '0, '0, 3'd0, 9, 0, 3'd7, 2'b00);
    idle(2'b00);
    idle(2'b01);
    check("dz_valid", rsp_valid, 2'b10);
    check("dz_result", rsp_result, 0);
    check("dz_flag", rsp_dz, 1'b1);
    idle(2'b10);

    // Backpressure with competing requests and non-owner ready
    step(2'b01, 100, 55, 3'd3, '0, '0, 3'd0, 2'b00);
    idle(2'b00);
    for (int i = 0; i < 5; i++) step(2'b11, 1, 2, 3'd4, 3, 4, 3'd4, 2'b10);
    idle(2'b01);

    // Conflict: both continuously valid
    do_reset(1'b0);
    obs_grant.delete();
    obs_result.delete();
    for (int i = 0; i < 12; i++) step(2'b11, 10, 3, 3'd5, 20, 4, 3'd5, 2'b11);
    check("conflict_count", obs_grant.size(), 4);
    for (int i = 0; i < 4 && i < obs_grant.size(); i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      check("conflict_grant", obs_grant[i], i % 2);
`else
      check("conflict_grant", obs_grant[i], 0);
`endif
    end
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (obs_result.size() >= 2) begin
      check("conflict_res0", obs_result[0], 7);
      check("conflict_res1", obs_result[1], 16);
    end else check("conflict_res_count", obs_result.size(), 2);
`else
    if (obs_result.size() >= 1) check("conflict_res0", obs_result[0], 7);
    else check("conflict_res_count", obs_result.size(), 1);
`endif

    // Reset during EXEC, then a normal op
    idle(2'b11);
    idle(2'b11);
    step(2'b01, 40, 2, 3'd7, '0, '0, 3'd0, 2'b00);
    do_reset(1'b1);
    idle(2'b11);
    check("post_rst_no_rsp", rsp_valid, 2'b00);
    step(2'b10, '0, '0, 3'd0, 6, 7, 3'd6, 2'b00);
    idle(2'b00);
    idle(2'b10);
    check("post_rst_result", rsp_result, 42);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom), $urandom, 32'($urandom_range(0, 9)), 3'($urandom),
           $urandom, 32'($urandom_range(0, 9)), 3'($urandom), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
